// File: rtl/i2c_regbank_pkg.sv
// Shared types and defaults for the I2C register-bank controller.
// No logic; the state enum is used by the top-level controller FSM.
// Optional feature macro: I2C_REGBANK_WPROT_EN (upper half read-only from I2C).
package i2c_regbank_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DW_DEF     = 8;

    typedef enum logic [1:0] {
        IDLE,
        PTR,
        WDATA,
        RDATA
    } state_t;

endpackage

// File: rtl/i2c_regbank_arb.sv
// Register array with fixed-priority access: I2C first, host in any free cycle.
// Latency: 1 cycle from accepted access to i2c_rd_valid / host_ack.
// Backpressure: the host waits while I2C uses the array, at most 1 cycle per I2C byte.
module i2c_regbank_arb
    import i2c_regbank_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DW     = DW_DEF
) (
    input  logic              clk,
    input  logic              rstn_sync,
    input  logic              i2c_we,
    input  logic              i2c_re,
    input  logic [ADDR_W-1:0] i2c_addr,
    input  logic [DW-1:0]     i2c_wdata,
    output logic              i2c_rd_valid,
    output logic [DW-1:0]     i2c_rd_data,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DW-1:0]     host_wdata,
    output logic              host_ack,
    output logic [DW-1:0]     host_rdata
);

    localparam int NREG = 2 ** ADDR_W;

    logic [DW-1:0] mem [NREG];
    logic          host_go;

    // host_ack masks the request for one cycle so a held request is not served twice
    assign host_go = host_req && !host_ack && !(i2c_we || i2c_re);

    always_ff @(posedge clk or negedge rstn_sync) begin
        if (!rstn_sync) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
            i2c_rd_valid <= 1'b0;
            i2c_rd_data  <= '0;
            host_ack     <= 1'b0;
            host_rdata   <= '0;
        end else begin
            i2c_rd_valid <= i2c_re;
            host_ack     <= host_go;
            if (i2c_we) begin
                mem[i2c_addr] <= i2c_wdata;
            end else if (host_go && host_we) begin
                mem[host_addr] <= host_wdata;
            end
            if (i2c_re) begin
                i2c_rd_data <= mem[i2c_addr];
            end
            if (host_go && !host_we) begin
                host_rdata <= mem[host_addr];
            end
        end
    end

endmodule

// File: rtl/i2c_regbank_ctrl.sv
// I2C register-bank controller: pointer/data phase decode, auto-increment pointer, host port.
// Latency: rd_req -> rd_valid 1 cycle, stop -> wr_done 1 cycle, host req -> ack 1 cycle when free.
// Backpressure: none toward I2C; host stalls behind I2C array accesses. Macro: I2C_REGBANK_WPROT_EN.
module i2c_regbank_ctrl
    import i2c_regbank_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DW     = DW_DEF
) (
    input  logic              clk,
    input  logic              rstn_in,
    input  logic              i2c_start,
    input  logic              i2c_dir,
    input  logic              i2c_stop,
    input  logic              i2c_wr_valid,
    input  logic [DW-1:0]     i2c_wr_data,
    input  logic              i2c_rd_req,
    output logic              i2c_rd_valid,
    output logic [DW-1:0]     i2c_rd_data,
    output logic              i2c_wr_done,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DW-1:0]     host_wdata,
    output logic              host_ack,
    output logic [DW-1:0]     host_rdata
);

    logic [1:0]        rst_sync;
    logic              rstn_sync;
    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic              written;
    logic              wr_ok;
    logic              bus_evt;
    logic              i2c_we;
    logic              i2c_re;

    // Assert immediately, release two clocks after rstn_in rises
    always_ff @(posedge clk or negedge rstn_in) begin
        if (!rstn_in) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end
    assign rstn_sync = rst_sync[1];

`ifdef I2C_REGBANK_WPROT_EN
    assign wr_ok = !ptr[ADDR_W-1];
`else
    assign wr_ok = 1'b1;
`endif

    assign bus_evt = i2c_start || i2c_stop;
    assign i2c_we  = !bus_evt && (state == WDATA) && i2c_wr_valid && wr_ok;
    assign i2c_re  = !bus_evt && (state == RDATA) && i2c_rd_req;

    always_ff @(posedge clk or negedge rstn_sync) begin
        if (!rstn_sync) begin
            state       <= IDLE;
            ptr         <= '0;
            written     <= 1'b0;
            i2c_wr_done <= 1'b0;
        end else begin
            i2c_wr_done <= i2c_stop && written;
            if (i2c_start) begin
                state   <= i2c_dir ? RDATA : PTR;
                written <= 1'b0;
            end else if (i2c_stop) begin
                state   <= IDLE;
                written <= 1'b0;
            end else begin
                case (state)
                    PTR: begin
                        if (i2c_wr_valid) begin
                            ptr   <= i2c_wr_data[ADDR_W-1:0];
                            state <= WDATA;
                        end
                    end
                    WDATA: begin
                        if (i2c_wr_valid) begin
                            ptr <= ptr + 1'b1;
                            if (wr_ok) begin
                                written <= 1'b1;
                            end
                        end
                    end
                    RDATA: begin
                        if (i2c_rd_req) begin
                            ptr <= ptr + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    i2c_regbank_arb #(
        .ADDR_W (ADDR_W),
        .DW     (DW)
    ) u_arb (
        .clk          (clk),
        .rstn_sync    (rstn_sync),
        .i2c_we       (i2c_we),
        .i2c_re       (i2c_re),
        .i2c_addr     (ptr),
        .i2c_wdata    (i2c_wr_data),
        .i2c_rd_valid (i2c_rd_valid),
        .i2c_rd_data  (i2c_rd_data),
        .host_req     (host_req),
        .host_we      (host_we),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .host_ack     (host_ack),
        .host_rdata   (host_rdata)
    );

endmodule

// File: tb/tb_i2c_regbank_ctrl.sv
// Scoreboard bench for i2c_regbank_ctrl: random I2C/host traffic against a register-map model.
// Honours I2C_REGBANK_WPROT_EN when the same macro is defined for the build.
module tb_i2c_regbank_ctrl;

    logic       clk = 1'b0;
    logic       rstn_in = 1'b0;
    logic       i2c_start = 1'b0, i2c_dir = 1'b0, i2c_stop = 1'b0;
    logic       i2c_wr_valid = 1'b0, i2c_rd_req = 1'b0;
    logic [7:0] i2c_wr_data = '0;
    logic       i2c_rd_valid, i2c_wr_done, host_ack;
    logic [7:0] i2c_rd_data, host_rdata;
    logic       host_req = 1'b0, host_we = 1'b0;
    logic [3:0] host_addr = '0;
    logic [7:0] host_wdata = '0;

    i2c_regbank_ctrl dut (
        .clk          (clk),
        .rstn_in      (rstn_in),
        .i2c_start    (i2c_start),
        .i2c_dir      (i2c_dir),
        .i2c_stop     (i2c_stop),
        .i2c_wr_valid (i2c_wr_valid),
        .i2c_wr_data  (i2c_wr_data),
        .i2c_rd_req   (i2c_rd_req),
        .i2c_rd_valid (i2c_rd_valid),
        .i2c_rd_data  (i2c_rd_data),
        .i2c_wr_done  (i2c_wr_done),
        .host_req     (host_req),
        .host_we      (host_we),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .host_ack     (host_ack),
        .host_rdata   (host_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] d;
        int         due;
        bit         chk_d;
    } exp_t;

    exp_t rd_q[$], host_q[$], done_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    // Reference model: register map, pointer and transaction phase
    logic [7:0] m_mem [16];
    int         m_ptr;
    int         m_phase;   // 0 idle, 1 expecting pointer, 2 writing, 3 reading
    bit         m_written;

    function automatic bit writable(input int a);
`ifdef I2C_REGBANK_WPROT_EN
        return a < 8;
`else
        return 1'b1;
`endif
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        m_ptr = 0;
        m_phase = 0;
        m_written = 0;
        rd_q.delete();
        host_q.delete();
        done_q.delete();
    endfunction

    function automatic void m_byte(input logic [7:0] d);
        if (m_phase == 1) begin
            m_ptr = d % 16;
            m_phase = 2;
        end else if (m_phase == 2) begin
            if (writable(m_ptr)) begin
                m_mem[m_ptr] = d;
                m_written = 1;
            end
            m_ptr = (m_ptr + 1) % 16;
        end
    endfunction

    task automatic compare(input string nm, input exp_t e, input logic [7:0] got);
        n_checks++;
        if (cyc != e.due || (e.chk_d && got !== e.d)) begin
            n_fail++;
            $display("FAIL %s: got data %h at cycle %0d, want data %h at cycle %0d",
                     nm, got, cyc, e.chk_d ? e.d : got, e.due);
        end
    endtask

    task automatic spurious(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: unexpected pulse at cycle %0d, want none", nm, cyc);
    endtask

    // Monitor: every DUT response pops its expected entry
    always @(negedge clk) begin
        if (i2c_rd_valid) begin
            if (rd_q.size() == 0) spurious("i2c_rd_valid");
            else compare("i2c_rd", rd_q.pop_front(), i2c_rd_data);
        end
        if (host_ack) begin
            if (host_q.size() == 0) spurious("host_ack");
            else compare("host", host_q.pop_front(), host_rdata);
        end
        if (i2c_wr_done) begin
            if (done_q.size() == 0) spurious("i2c_wr_done");
            else compare("wr_done", done_q.pop_front(), 8'h00);
        end
    end

    task automatic i2c_start_t(input bit dir);
        @(posedge clk); #1;
        i2c_start = 1'b1; i2c_dir = dir;
        m_phase = dir ? 3 : 1;
        m_written = 0;
        @(posedge clk); #1;
        i2c_start = 1'b0; i2c_dir = 1'b0;
    endtask

    task automatic i2c_byte(input logic [7:0] d);
        @(posedge clk); #1;
        i2c_wr_valid = 1'b1; i2c_wr_data = d;
        m_byte(d);
        @(posedge clk); #1;
        i2c_wr_valid = 1'b0;
    endtask

    task automatic i2c_read();
        exp_t e;
        @(posedge clk); #1;
        i2c_rd_req = 1'b1;
        if (m_phase == 3) begin
            e.d = m_mem[m_ptr]; e.due = cyc + 1; e.chk_d = 1;
            rd_q.push_back(e);
            m_ptr = (m_ptr + 1) % 16;
        end
        @(posedge clk); #1;
        i2c_rd_req = 1'b0;
    endtask

    task automatic i2c_stop_t();
        exp_t e;
        @(posedge clk); #1;
        i2c_stop = 1'b1;
        if (m_written) begin
            e.d = 8'h00; e.due = cyc + 1; e.chk_d = 0;
            done_q.push_back(e);
        end
        m_phase = 0;
        m_written = 0;
        @(posedge clk); #1;
        i2c_stop = 1'b0;
    endtask

    task automatic wait_ack();
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (host_ack) seen = 1;
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL host_timeout: got no host_ack within 20 cycles, want one");
        end
    endtask

    task automatic host_access(input bit we, input int a, input logic [7:0] d);
        exp_t e;
        @(posedge clk); #1;
        host_req = 1'b1; host_we = we; host_addr = 4'(a); host_wdata = d;
        e.d = m_mem[a]; e.due = cyc + 1; e.chk_d = !we;
        host_q.push_back(e);
        if (we) m_mem[a] = d;
        wait_ack();
        @(posedge clk); #1;
        host_req = 1'b0;
    endtask

    task automatic drained();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (rd_q.size() + host_q.size() + done_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_response: got %0d/%0d/%0d outstanding rd/host/done, want 0/0/0",
                     rd_q.size(), host_q.size(), done_q.size());
            rd_q.delete(); host_q.delete(); done_q.delete();
        end
    endtask

    task automatic check_outputs_zero(input string nm);
        n_checks++;
        if ({i2c_rd_valid, i2c_rd_data, i2c_wr_done, host_ack, host_rdata} !== '0) begin
            n_fail++;
            $display("FAIL %s: got rdv=%b rd=%h done=%b ack=%b hrd=%h, want all 0",
                     nm, i2c_rd_valid, i2c_rd_data, i2c_wr_done, host_ack, host_rdata);
        end
    endtask

    task automatic dump_all();
        for (int i = 0; i < 16; i++) host_access(1'b0, i, 8'h00);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no end of test, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   n;
        m_reset();
        repeat (3) @(posedge clk);
        #1 check_outputs_zero("reset_outputs");
        rstn_in = 1'b1;
        repeat (4) @(posedge clk);
        dump_all();

        // Pointer 0x03, two data bytes, then Sr read of three bytes
        i2c_start_t(0); i2c_byte(8'h03); i2c_byte(8'hA5); i2c_byte(8'h5A); i2c_stop_t();
        drained();
        i2c_start_t(0); i2c_byte(8'h03); i2c_start_t(1);
        repeat (3) i2c_read();
        i2c_stop_t();
        drained();

        // Wrap from 15 to 0, with upper pointer bits ignored
        i2c_start_t(0); i2c_byte(8'hFF); i2c_byte(8'h11); i2c_byte(8'h22); i2c_stop_t();
        host_access(1'b0, 15, 8'h00); host_access(1'b0, 0, 8'h00);
        drained();

        // Same-cycle host and I2C write to index 4: host lands one cycle later and wins
        i2c_start_t(0); i2c_byte(8'h04);
        @(posedge clk); #1;
        i2c_wr_valid = 1'b1; i2c_wr_data = 8'h33;
        host_req = 1'b1; host_we = 1'b1; host_addr = 4'd4; host_wdata = 8'h77;
        m_byte(8'h33);
        e.d = 8'h00; e.due = cyc + 2; e.chk_d = 0;
        host_q.push_back(e);
        m_mem[4] = 8'h77;
        @(posedge clk); #1;
        i2c_wr_valid = 1'b0;
        wait_ack();
        @(posedge clk); #1;
        host_req = 1'b0;
        i2c_stop_t();
        host_access(1'b0, 4, 8'h00);
        drained();

        // Pointer-only write: no wr_done; then write 0x99 to index 8 and read back from ptr
        i2c_start_t(0); i2c_byte(8'h06); i2c_stop_t();
        drained();
        i2c_start_t(0); i2c_byte(8'h08); i2c_byte(8'h99); i2c_stop_t();
        i2c_start_t(1); i2c_read(); i2c_stop_t();
        host_access(1'b0, 8, 8'h00);
        drained();

        // Random traffic
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 2))
                0: begin
                    i2c_start_t(0);
                    i2c_byte(8'($urandom));
                    n = $urandom_range(0, 4);
                    for (int b = 0; b < n; b++) begin
                        i2c_byte(8'($urandom));
                        if ($urandom_range(0, 3) == 0)
                            host_access(1'($urandom), $urandom_range(0, 15), 8'($urandom));
                    end
                    i2c_stop_t();
                end
                1: begin
                    if ($urandom_range(0, 1) == 1) begin
                        i2c_start_t(0);
                        i2c_byte(8'($urandom));
                    end
                    i2c_start_t(1);
                    n = $urandom_range(1, 5);
                    for (int b = 0; b < n; b++) begin
                        i2c_read();
                        if ($urandom_range(0, 3) == 0) i2c_byte(8'($urandom));
                    end
                    i2c_stop_t();
                end
                default: host_access(1'($urandom), $urandom_range(0, 15), 8'($urandom));
            endcase
            drained();
        end
        dump_all();
        drained();

        // Reset in the middle of a write phase, with a byte in flight
        i2c_start_t(0); i2c_byte(8'h05); i2c_byte(8'h44);
        drained();
        @(posedge clk); #1;
        i2c_wr_valid = 1'b1; i2c_wr_data = 8'h66;
        #2 rstn_in = 1'b0;
        #1 check_outputs_zero("reset_mid_write");
        m_reset();
        @(posedge clk); #1;
        i2c_wr_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn_in = 1'b1;
        repeat (4) @(posedge clk);
        #1 check_outputs_zero("post_reset_outputs");
        i2c_start_t(1); i2c_read(); i2c_read(); i2c_stop_t();
        dump_all();
        i2c_start_t(0); i2c_byte(8'h0E); i2c_byte(8'hC3); i2c_byte(8'h3C); i2c_stop_t();
        dump_all();
        drained();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
